// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: bit-serial, LSB-first magnitude comparator.
// One operand bit pair is examined per clock. A differing bit overrides
// the working flag, so the most significant difference decides the result.
// gt/eq/lt are registered, exactly one-hot after the first result, and
// hold their value until the edge that raises done.
//
// Optional feature: define SIGNED_CMP_EN for two's-complement comparison.
// In that build the sign bit carries inverted weight. Latency and
// handshake are the same as in the unsigned build.
//
// Handshake: start is sampled only while busy=0. The accepting edge
// captures A/B. busy stays high for WIDTH cycles. done pulses for one
// cycle on the edge that updates gt/eq/lt. start in the done cycle is
// accepted, so back-to-back comparisons run with a WIDTH+1 cycle period.
module serial_mag_cmp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic { S_IDLE = 1'b0, S_SHIFT = 1'b1 } state_t;
  typedef enum logic [1:0] { F_EQ = 2'd0, F_GT = 2'd1, F_LT = 2'd2 } flag_t;

  state_t           state_q, state_d;
  flag_t            flag_q, flag_d;
  flag_t            next_flag;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             bit_a, bit_b;
  logic             last_bit;

  // Per-bit flag update: a differing bit overrides; the sign bit is inverted in signed mode
  always_comb begin
    bit_a     = sha_q[0];
    bit_b     = shb_q[0];
    last_bit  = (cnt_q == LAST);
    next_flag = flag_q;
    if (bit_a && !bit_b) begin
      next_flag = F_GT;
    end else if (!bit_a && bit_b) begin
      next_flag = F_LT;
    end
`ifdef SIGNED_CMP_EN
    if (last_bit && (bit_a != bit_b)) begin
      next_flag = bit_a ? F_LT : F_GT;
    end
`else
`endif
  end

  // Next-state and datapath: load on accept, shift one bit per cycle, publish on last bit
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sha_d   = A;
          shb_d   = B;
          cnt_d   = '0;
          flag_d  = F_EQ;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        flag_d = next_flag;
        sha_d  = sha_q >> 1;
        shb_d  = shb_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          gt_d    = (next_flag == F_GT);
          eq_d    = (next_flag == F_EQ);
          lt_d    = (next_flag == F_LT);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset abandons any comparison in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      flag_q  <= F_EQ;
      sha_q   <= '0;
      shb_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
Bit-serial, LSB-first magnitude comparator. It is the sequential counterpart of the team's parallel MSB-first 32-bit A>B comparator. The block trades a single-cycle wide AND/OR tree for one bit per clock, with a start/busy/done handshake. It produces registered greater/equal/less flags, and sits beside the ALU/compare datapath wherever comparison area matters more than latency.

Parameters:
WIDTH, 32, operand width in bits; legal range is WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
A  input  WIDTH  operand A; captured on the accepting edge
B  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  comparison in progress
done  output  1  one-cycle pulse when results update
gt  output  1  A > B (registered)
eq  output  1  A == B (registered)
lt  output  1  A < B (registered)

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, gt=0, eq=0, lt=0. Internal state returns to IDLE. Shift registers, bit counter and working flag are cleared.
- Reset mid-operation: the comparison is abandoned immediately, with no done pulse and outputs at reset values.
- State machine: IDLE -> SHIFT -> IDLE.
  - IDLE: on an edge with start=1, load shA<=A and shB<=B, cnt<=0, working flag<=EQ, busy<=1, then go to SHIFT.
  - SHIFT: each edge examines bit a=shA[0], b=shB[0] and updates the working flag.
    - a=1, b=0: flag<=GT.
    - a=0, b=1: flag<=LT.
    - a==b: flag unchanged.
    - Then shA, shB shift right by 1 and cnt increments.
  - A later (more significant) differing bit always overrides an earlier one, so the final flag is the magnitude result.
  - The SHIFT edge that processes bit WIDTH-1 (cnt==WIDTH-1) also does the following: writes gt/eq/lt from the final flag (exactly one-hot), sets done<=1, busy<=0, and returns to IDLE.
- Latency: if start is accepted at edge t, bits are processed at edges t+1 .. t+WIDTH. Results and done become valid after edge t+WIDTH and done clears at edge t+WIDTH+1.
- busy is high from after edge t until edge t+WIDTH.
- start while busy=1 is ignored; operands are not re-sampled.
- start high in the cycle where done=1 (busy=0) is accepted. That gives back-to-back operation with a WIDTH+1 cycle period, and done still pulses only one cycle.
- gt/eq/lt hold their last result during a new comparison and change only on the edge that raises done.
- A/B changing after the accepting edge has no effect.
- Counter width is $clog2(WIDTH); no wrap-around occurs because cnt resets on each accept.

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined: operands are treated as two's complement. On the edge processing bit WIDTH-1, if a!=b, the flag becomes LT when a=1 (A negative) and GT when b=1. In other words, the sign bit has inverted weight; all other bits behave as in the unsigned case. Latency and handshake are unchanged.
- Undefined: unsigned comparison only, matching the existing parallel comparator.

Test Plan:
- Reset check: hold rst_n=0 -> busy=0, done=0, gt=eq=lt=0. Then A=5, B=3, start 1 cycle -> after 32 edges done=1 for exactly 1 cycle with gt=1, eq=0, lt=0, and busy low on the same edge.
- Tie and LSB override: A=B=0xDEADBEEF -> eq=1. Then A=0x00000001, B=0x00000000 -> gt=1. Then A=0x80000000, B=0x7FFFFFFF -> gt=1 unsigned, lt=1 with SIGNED_CMP_EN.
- MSB override: A=0x00000002, B=0x00000001 -> gt=1. Then A=0x00010000, B=0x0000FFFF -> gt=1. Then A=0x0000FFFF, B=0x00010000 -> lt=1.
- Handshake: pulse start again at cycle 10 of a busy comparison with different operands -> ignored, first result unchanged. Assert start in the done cycle with A=1, B=2 -> accepted, lt=1 exactly 33 cycles after the previous done.
- Reset mid-operation: drop rst_n asynchronously (not clock-aligned) at cycle 15 -> all outputs go 0 immediately and no done pulse occurs. After release, a new compare with A=7, B=7 gives eq=1.
- Random: 10k random A/B with random start gaps, checked against a scoreboard `$unsigned` compare (`$signed` with SIGNED_CMP_EN) -> flags exactly one-hot and matching on every done pulse.
